fifo_sync_fwft: RTL
===================

Name: fifo_sync_fwft

Overview:
- Parametrised single-clock FIFO with first-word-fall-through (FWFT) output, replacing fixed-size 8-bit FIFO wrappers.
- Generic in width and depth, with programmable almost-empty/almost-full levels and an exact occupancy count.
- Used for byte and word buffering between the serial bridge and Wishbone-side logic inside one clock domain.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH_LOG2, 9, log2 of total capacity; DEPTH = 2**DEPTH_LOG2 entries.
- AEMPTY_LEV, 2, aempty asserted when count <= AEMPTY_LEV.
- AFULL_LEV, 510, afull asserted when count >= AFULL_LEV; must be <= DEPTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_data  in  WIDTH  write data.
- wr_en  in  1  push request; accepted only when full==0.
- full  out  1  count == DEPTH.
- afull  out  1  count >= AFULL_LEV.
- rd_data  out  WIDTH  head-of-FIFO data; valid whenever empty==0.
- rd_en  in  1  pop/acknowledge of rd_data; honoured only when empty==0.
- empty  out  1  no valid word presented on rd_data.
- aempty  out  1  count <= AEMPTY_LEV.
- count  out  DEPTH_LOG2+1  words held, including the word presented on rd_data.

Behaviour:
- Reset, sampled on a clk edge with reset=1:
  - Pointers and count go to 0; output-valid flag (dvld) is cleared.
  - Resulting outputs: empty=1, aempty=1, full=0, afull=(AFULL_LEV==0), rd_data=0.
  - Reset mid-operation discards all contents; no partial state survives.
- Storage:
  - RAM with registered read (fifo_sync_ram) feeding a one-word output register.
  - The output register counts toward capacity; the RAM holds at most DEPTH-1 words while dvld=1.
- Write:
  - wr_en && !full writes wr_data at wr_ptr, then wr_ptr+1 with natural modulo-DEPTH wrap.
  - wr_en while full is ignored: no pointer change, data dropped.
- FWFT prefetch:
  - Whenever dvld==0 and RAM is non-empty, the head word is loaded into the output register automatically.
  - Write to an empty FIFO at edge k: count=1 after edge k; empty falls after edge k+1 with rd_data = that word.
- Read:
  - rd_en && !empty consumes rd_data.
  - If RAM is non-empty in the same cycle, the next word loads so empty stays 0 with no bubble.
  - Otherwise dvld clears and empty rises after that edge.
  - rd_en while empty is ignored.
- Count:
  - count +1 on an accepted write, -1 on an accepted read, unchanged when both or neither happen.
  - full, afull and aempty are registered and derived from the next-state count, so they are consistent with count every cycle.
- Simultaneous events:
  - full with wr_en and rd_en: the read is taken, the write is rejected (full gates on the current cycle).
  - empty with wr_en and rd_en: the write is taken, the read is ignored.
- Back-to-back throughput is one word per clock in both directions.

Optional Feature:
- Macro: FIFO_SYNC_ERR_EN.
- When defined, three ports are added:
  - overflow out 1 — sticky; set by wr_en while full.
  - underflow out 1 — sticky; set by rd_en while empty.
  - err_clr in 1 — synchronous clear of both flags; a set event in the same cycle as err_clr wins.
  - Both flags reset to 0.
- When undefined, these ports and their logic are absent; illegal requests are silently ignored as described above.

Decomposition:
- Shared package fifo_sync_pkg:
  - clog2 constant function.
  - Default WIDTH/DEPTH_LOG2 localparams.
  - Helper for the default AFULL_LEV (DEPTH-2).
- Sub-module fifo_sync_ram:
  - Simple dual-port, one write port and one registered read port, parameters WIDTH and DEPTH_LOG2.
  - Infers block RAM; no reset on the array.

Test Plan:
- Reset, then a single write 0xA5 at edge k: count=1 after edge k; empty=0 and rd_data=0xA5 after edge k+1; rd_en one cycle -> empty=1, count=0.
- Fill DEPTH=512 with values 0..511: afull rises when count reaches 510, full at 512; a 513th wr_en is dropped; drain reads back 0..511 in order.
- Continuous simultaneous wr_en/rd_en for 2000 cycles from count=5: count stays 5, data in order, pointers wrap cleanly.
- full with wr_en=rd_en=1: count drops to 511 and the written word is absent; empty with wr_en=rd_en=1: count becomes 1 and the word is later presented.
- Assert reset with count=300 mid-burst: next cycle count=0, empty=1, full=0; a subsequent write/read returns only post-reset data.
- FIFO_SYNC_ERR_EN defined: rd_en while empty -> underflow=1 and held; err_clr -> 0; wr_en at full together with err_clr -> overflow=1.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// Shared constants and helpers for the synchronous FWFT FIFO and its RAM.
package fifo_sync_pkg;

  localparam int FIFO_DEF_WIDTH      = 8;
  localparam int FIFO_DEF_DEPTH_LOG2 = 9;

  function automatic int fifo_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

  // Leaves two words of headroom so upstream sees afull before the last slots go.
  function automatic int fifo_afull_default(input int depth_log2);
    return (1 << depth_log2) - 2;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port RAM: one write port and one read port with a registered output.
module fifo_sync_ram
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH      = FIFO_DEF_WIDTH,
  parameter int DEPTH_LOG2 = FIFO_DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o
);

  logic [WIDTH-1:0] mem_q [0:(1 << DEPTH_LOG2)-1];
  logic [WIDTH-1:0] rd_data_q;

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock first-word-fall-through FIFO with exact count and almost flags.
// Optional sticky overflow/underflow flags are built when FIFO_SYNC_ERR_EN is defined.
module fifo_sync_fwft
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH      = FIFO_DEF_WIDTH,
  parameter int DEPTH_LOG2 = FIFO_DEF_DEPTH_LOG2,
  parameter int AEMPTY_LEV = 2,
  parameter int AFULL_LEV  = fifo_afull_default(DEPTH_LOG2)
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef FIFO_SYNC_ERR_EN
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow,
`endif
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  afull,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  aempty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int AW = DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(1 << DEPTH_LOG2);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_LEV);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_LEV);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dvld_q, dvld_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             wr_ok, rd_ok, ram_re, ram_has_data;
  logic [WIDTH-1:0] ram_rdata;

  // The RAM read register doubles as the output word; dvld marks it as holding live data.
  fifo_sync_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_en_i   (ram_re),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rdata)
  );

  always_comb begin
    wr_ok        = wr_en && !full_q;
    rd_ok        = rd_en && dvld_q;
    ram_has_data = count_q > CW'(dvld_q);
    ram_re       = ram_has_data && (!dvld_q || rd_ok);
    wr_ptr_d     = wr_ok  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = ram_re ? rd_ptr_q + AW'(1) : rd_ptr_q;
    dvld_d       = ram_re || (dvld_q && !rd_ok);
    count_d      = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - CW'(1);
    end
    full_d   = (count_d == DEPTH_C);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dvld_q   <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= (AF_C == '0);
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dvld_q   <= dvld_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign rd_data = dvld_q ? ram_rdata : '0;
  assign empty   = !dvld_q;
  assign full    = full_q;
  assign afull   = afull_q;
  assign aempty  = aempty_q;
  assign count   = count_q;

`ifdef FIFO_SYNC_ERR_EN
  logic overflow_q, underflow_q;

  // A new violation in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full_q) begin
        overflow_q <= 1'b1;
      end else if (err_clr) begin
        overflow_q <= 1'b0;
      end
      if (rd_en && !dvld_q) begin
        underflow_q <= 1'b1;
      end else if (err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule
